// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter
// Sequencer and arbiter for the single external memory bus. Two requesters
// (instruction fetch and load/store) are granted one at a time; the block
// drives the external command, address and write data, waits for BusReady,
// returns read data with a one-cycle Ack, and aborts a transfer that waits
// TIMEOUT_CYCLES cycles without BusReady.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   IfReq/IfAddr             fetch request and address (held until IfAck)
//   IfAck/IfData             fetch done pulse and fetched instruction
//   DataReq/DataWrite        load/store request and direction
//   DataAddr/DataWData       load/store address and store data
//   DataAck/DataRData        load/store done pulse and load data
//   BusCmd                   000 idle, 001 fetch, 010 read, 011 write
//   BusAddr/BusWData/BusWEn  external address, write data, write enable
//   BusRData/BusReady        external read data and completion handshake
//   Timeout                  pulses together with the Ack of an aborted transfer
module ext_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IfReq,
    input  logic [31:0] IfAddr,
    output logic        IfAck,
    output logic [31:0] IfData,
    input  logic        DataReq,
    input  logic        DataWrite,
    input  logic [31:0] DataAddr,
    input  logic [31:0] DataWData,
    output logic        DataAck,
    output logic [31:0] DataRData,
    output logic [2:0]  BusCmd,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic        BusWEn,
    input  logic [31:0] BusRData,
    input  logic        BusReady,
    output logic        Timeout
);

    typedef enum logic [2:0] {IDLE, FETCH, DREAD, DWRITE, TURN} state_t;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_FETCH = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_WRITE = 3'b011;

    // Abort fires on the cycle the counter would step onto TIMEOUT_CYCLES.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        last_was_data;
    logic        data_wins;

    // Data is granted when it is the only requester, or on a tie when the
    // previous completed transfer was a fetch (data wins the first tie).
    assign data_wins = DataReq && (!IfReq || !last_was_data);

    // Single sequencer: arbitration, bus drive, wait counting and the
    // registered Ack/Timeout pulses all live here so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            last_was_data <= 1'b0;
            BusCmd        <= CMD_IDLE;
            BusAddr       <= '0;
            BusWData      <= '0;
            BusWEn        <= 1'b0;
            IfAck         <= 1'b0;
            DataAck       <= 1'b0;
            Timeout       <= 1'b0;
            IfData        <= '0;
            DataRData     <= '0;
        end else begin
            IfAck   <= 1'b0;
            DataAck <= 1'b0;
            Timeout <= 1'b0;

            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (data_wins) begin
                        BusAddr <= DataAddr;
                        if (DataWrite) begin
                            BusWData <= DataWData;
                            BusWEn   <= 1'b1;
                            BusCmd   <= CMD_WRITE;
                            state    <= DWRITE;
                        end else begin
                            BusCmd <= CMD_READ;
                            state  <= DREAD;
                        end
                    end else if (IfReq) begin
                        BusAddr <= IfAddr;
                        BusCmd  <= CMD_FETCH;
                        state   <= FETCH;
                    end
                end

                FETCH, DREAD, DWRITE: begin
                    if (BusReady) begin
                        // Ready wins even on the terminal-count cycle.
                        if (state == FETCH) begin
                            IfAck  <= 1'b1;
                            IfData <= BusRData;
                        end else begin
                            DataAck <= 1'b1;
                            if (state == DREAD) begin
                                DataRData <= BusRData;
                            end
                        end
                        last_was_data <= (state != FETCH);
                        BusCmd        <= CMD_IDLE;
                        BusWEn        <= 1'b0;
                        state         <= TURN;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == LAST_WAIT) begin
                            // Abort: the owner still gets its Ack so the core
                            // never stalls, and a read returns zero. An aborted
                            // transfer still counts as service for fairness.
                            Timeout <= 1'b1;
                            if (state == FETCH) begin
                                IfAck  <= 1'b1;
                                IfData <= '0;
                            end else begin
                                DataAck <= 1'b1;
                                if (state == DREAD) begin
                                    DataRData <= '0;
                                end
                            end
                            last_was_data <= (state != FETCH);
                            BusCmd        <= CMD_IDLE;
                            BusWEn        <= 1'b0;
                            state         <= TURN;
                        end
                    end
                end

                TURN: begin
                    // One dead cycle: a Req still high during its Ack cycle is
                    // not re-granted, and the bus gets a turnaround cycle.
                    state <= IDLE;
                end

                default: begin
                    BusCmd <= CMD_IDLE;
                    BusWEn <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Self-checking bench for ext_bus_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level model of arbitration.
module tb_ext_bus_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        IfReq;
    logic [31:0] IfAddr;
    logic        IfAck;
    logic [31:0] IfData;
    logic        DataReq;
    logic        DataWrite;
    logic [31:0] DataAddr;
    logic [31:0] DataWData;
    logic        DataAck;
    logic [31:0] DataRData;
    logic [2:0]  BusCmd;
    logic [31:0] BusAddr;
    logic [31:0] BusWData;
    logic        BusWEn;
    logic [31:0] BusRData;
    logic        BusReady;
    logic        Timeout;

    int checks = 0;
    int errors = 0;

    // What one transfer looked like from the outside.
    typedef struct packed {
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic        held_ok;
        logic [2:0]  acks;      // {IfAck, DataAck, Timeout} in the Ack cycle
        logic [31:0] if_data;
        logic [31:0] d_rdata;
        logic [2:0]  cmd_after;
        logic        wen_after;
        logic [2:0]  turn_acks;
    } obs_t;

    ext_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .IfReq(IfReq), .IfAddr(IfAddr), .IfAck(IfAck), .IfData(IfData),
        .DataReq(DataReq), .DataWrite(DataWrite), .DataAddr(DataAddr),
        .DataWData(DataWData), .DataAck(DataAck), .DataRData(DataRData),
        .BusCmd(BusCmd), .BusAddr(BusAddr), .BusWData(BusWData), .BusWEn(BusWEn),
        .BusRData(BusRData), .BusReady(BusReady), .Timeout(Timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        IfReq = 0; IfAddr = '0; DataReq = 0; DataWrite = 0;
        DataAddr = '0; DataWData = '0; BusReady = 0; BusRData = '0;
    endtask

    task automatic do_reset;
        rst = 1;
        tick;
        tick;
        rst = 0;
    endtask

    // Runs one transfer from IDLE: grant edge, k-1 wait cycles, then the
    // edge where BusReady is (or is not) seen, then the TURN edge.
    task automatic do_xfer(input int k, input bit ready_at_end,
                           input logic [31:0] rdata, output obs_t o);
        o = '0;
        BusReady = 0;
        tick;
        o.cmd = BusCmd; o.addr = BusAddr; o.wen = BusWEn; o.wdata = BusWData;
        o.held_ok = ({IfAck, DataAck, Timeout} == 3'b000);
        for (int i = 1; i < k; i++) begin
            BusRData = $urandom;
            tick;
            if (BusCmd !== o.cmd || BusAddr !== o.addr || BusWEn !== o.wen ||
                BusWData !== o.wdata || {IfAck, DataAck, Timeout} !== 3'b000)
                o.held_ok = 1'b0;
        end
        BusReady = ready_at_end;
        BusRData = rdata;
        tick;
        o.acks = {IfAck, DataAck, Timeout};
        o.if_data = IfData; o.d_rdata = DataRData;
        o.cmd_after = BusCmd; o.wen_after = BusWEn;
        BusReady = 0;
        BusRData = $urandom;
        tick;
        o.turn_acks = {IfAck, DataAck, Timeout};
    endtask

    task automatic test_reset;
        idle_inputs;
        do_reset;
        checks++;
        if ({BusCmd, BusWEn, IfAck, DataAck, Timeout} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0", {BusCmd, BusWEn, IfAck, DataAck, Timeout});
        end
        checks++;
        if ({BusAddr, BusWData, IfData, DataRData} !== 128'b0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 0", {BusAddr, BusWData, IfData, DataRData});
        end
    endtask

    task automatic test_single_fetch;
        obs_t o;
        idle_inputs;
        do_reset;
        IfReq = 1; IfAddr = 32'h100;
        do_xfer(2, 1, 32'hDEADBEEF, o);
        IfReq = 0;
        checks++;
        if ({o.cmd, o.addr, o.wen} !== {3'b001, 32'h100, 1'b0}) begin
            errors++;
            $display("[TB] FAIL fetch_grant: got %h expected %h", {o.cmd, o.addr, o.wen}, {3'b001, 32'h100, 1'b0});
        end
        checks++;
        if (o.held_ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fetch_hold: got %b expected 1", o.held_ok);
        end
        checks++;
        if ({o.acks, o.if_data} !== {3'b100, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL fetch_ack: got %h expected %h", {o.acks, o.if_data}, {3'b100, 32'hDEADBEEF});
        end
        checks++;
        if ({o.cmd_after, o.turn_acks} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL fetch_turn: got %b expected 0", {o.cmd_after, o.turn_acks});
        end
    endtask

    task automatic test_store;
        obs_t o;
        idle_inputs;
        do_reset;
        DataReq = 1; DataWrite = 1; DataAddr = 32'h2000; DataWData = 32'h12345678;
        do_xfer(3, 1, 32'hCAFEF00D, o);
        DataReq = 0;
        checks++;
        if ({o.cmd, o.wen, o.addr, o.wdata} !== {3'b011, 1'b1, 32'h2000, 32'h12345678}) begin
            errors++;
            $display("[TB] FAIL store_grant: got %h expected %h", {o.cmd, o.wen, o.addr, o.wdata},
                     {3'b011, 1'b1, 32'h2000, 32'h12345678});
        end
        checks++;
        if (o.held_ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL store_hold: got %b expected 1", o.held_ok);
        end
        checks++;
        if ({o.acks, o.wen_after, o.cmd_after, o.turn_acks} !== {3'b010, 1'b0, 3'b000, 3'b000}) begin
            errors++;
            $display("[TB] FAIL store_ack: got %b expected %b", {o.acks, o.wen_after, o.cmd_after, o.turn_acks},
                     {3'b010, 1'b0, 3'b000, 3'b000});
        end
    endtask

    task automatic test_contention;
        obs_t o;
        logic [2:0]  exp_cmd;
        logic [31:0] exp_if;
        logic [31:0] rd;
        idle_inputs;
        IfReq = 1; IfAddr = 32'h400; DataReq = 1; DataWrite = 0; DataAddr = 32'h800;
        do_reset;
        exp_if = '0;
        for (int i = 0; i < 4; i++) begin
            exp_cmd = (i % 2 == 0) ? 3'b010 : 3'b001;
            rd = $urandom;
            do_xfer(1, 1, rd, o);
            checks++;
            if ({o.cmd, o.addr} !== {exp_cmd, (i % 2 == 0) ? 32'h800 : 32'h400}) begin
                errors++;
                $display("[TB] FAIL contention_grant%0d: got %h expected %h", i, {o.cmd, o.addr},
                         {exp_cmd, (i % 2 == 0) ? 32'h800 : 32'h400});
            end
            checks++;
            if ({o.acks, o.turn_acks, o.held_ok} !== {(i % 2 == 0) ? 3'b010 : 3'b100, 3'b000, 1'b1}) begin
                errors++;
                $display("[TB] FAIL contention_ack%0d: got %b expected %b", i, {o.acks, o.turn_acks, o.held_ok},
                         {(i % 2 == 0) ? 3'b010 : 3'b100, 3'b000, 1'b1});
            end
            if (i % 2 == 1) exp_if = rd;
            checks++;
            if (o.if_data !== exp_if) begin
                errors++;
                $display("[TB] FAIL contention_ifdata%0d: got %h expected %h", i, o.if_data, exp_if);
            end
        end
        IfReq = 0; DataReq = 0;
    endtask

    task automatic test_timeout;
        obs_t o;
        idle_inputs;
        do_reset;
        DataReq = 1; DataWrite = 0; DataAddr = 32'h44;
        do_xfer(1, 1, 32'h5555AAAA, o);
        checks++;
        if (o.d_rdata !== 32'h5555AAAA) begin
            errors++;
            $display("[TB] FAIL timeout_preload: got %h expected %h", o.d_rdata, 32'h5555AAAA);
        end
        DataAddr = 32'h40;
        do_xfer(TO, 0, 32'hFFFFFFFF, o);
        DataReq = 0;
        checks++;
        if ({o.cmd, o.addr, o.held_ok} !== {3'b010, 32'h40, 1'b1}) begin
            errors++;
            $display("[TB] FAIL timeout_wait: got %h expected %h", {o.cmd, o.addr, o.held_ok}, {3'b010, 32'h40, 1'b1});
        end
        checks++;
        if ({o.acks, o.d_rdata, o.turn_acks} !== {3'b011, 32'h0, 3'b000}) begin
            errors++;
            $display("[TB] FAIL timeout_abort: got %h expected %h", {o.acks, o.d_rdata, o.turn_acks},
                     {3'b011, 32'h0, 3'b000});
        end
        IfReq = 1; IfAddr = 32'h900;
        do_xfer(2, 1, 32'h0BADC0DE, o);
        IfReq = 0;
        checks++;
        if ({o.cmd, o.acks, o.if_data} !== {3'b001, 3'b100, 32'h0BADC0DE}) begin
            errors++;
            $display("[TB] FAIL timeout_recover: got %h expected %h", {o.cmd, o.acks, o.if_data},
                     {3'b001, 3'b100, 32'h0BADC0DE});
        end
    endtask

    task automatic test_boundary_ready;
        obs_t o;
        idle_inputs;
        do_reset;
        DataReq = 1; DataWrite = 0; DataAddr = 32'h60;
        do_xfer(TO, 1, 32'h13579BDF, o);
        DataReq = 0;
        checks++;
        if ({o.acks, o.d_rdata, o.held_ok} !== {3'b010, 32'h13579BDF, 1'b1}) begin
            errors++;
            $display("[TB] FAIL boundary_load: got %h expected %h", {o.acks, o.d_rdata, o.held_ok},
                     {3'b010, 32'h13579BDF, 1'b1});
        end
        IfReq = 1; IfAddr = 32'h64;
        do_xfer(TO, 1, 32'h2468ACE0, o);
        IfReq = 0;
        checks++;
        if ({o.acks, o.if_data} !== {3'b100, 32'h2468ACE0}) begin
            errors++;
            $display("[TB] FAIL boundary_fetch: got %h expected %h", {o.acks, o.if_data}, {3'b100, 32'h2468ACE0});
        end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        logic [2:0] cmd_seen;
        idle_inputs;
        do_reset;
        IfReq = 1; IfAddr = 32'h200;
        do_xfer(1, 1, 32'hA5A5A5A5, o);
        IfAddr = 32'h300;
        tick;
        cmd_seen = BusCmd;
        tick;
        rst = 1;
        tick;
        checks++;
        if (cmd_seen !== 3'b001) begin
            errors++;
            $display("[TB] FAIL midreset_grant: got %b expected 001", cmd_seen);
        end
        checks++;
        if ({BusCmd, BusWEn, IfAck, DataAck, Timeout, BusAddr, BusWData, IfData, DataRData} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %h expected 0",
                     {BusCmd, BusWEn, IfAck, DataAck, Timeout, BusAddr, BusWData, IfData, DataRData});
        end
        rst = 0;
        do_xfer(2, 1, 32'h77778888, o);
        IfReq = 0;
        checks++;
        if ({o.cmd, o.addr, o.acks, o.if_data} !== {3'b001, 32'h300, 3'b100, 32'h77778888}) begin
            errors++;
            $display("[TB] FAIL midreset_after: got %h expected %h", {o.cmd, o.addr, o.acks, o.if_data},
                     {3'b001, 32'h300, 3'b100, 32'h77778888});
        end
    endtask

    // Model: a tie goes to whichever side was not served last; each
    // completed transfer updates the returned-data registers it owns.
    task automatic test_random;
        obs_t o;
        bit          m_last_data;
        logic [31:0] m_if, m_dr, rd;
        int          scen, k;
        bit          dwins;
        logic [2:0]  e_cmd;
        logic [31:0] e_addr;
        idle_inputs;
        do_reset;
        m_last_data = 0; m_if = '0; m_dr = '0;
        for (int it = 0; it < 30; it++) begin
            scen = $urandom_range(0, 3);
            IfAddr = $urandom; DataAddr = $urandom; DataWData = $urandom;
            IfReq = (scen == 0 || scen == 3);
            DataReq = (scen != 0);
            DataWrite = (scen == 2) ? 1'b1 : (scen == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            while (IfReq || DataReq) begin
                dwins = DataReq && (!IfReq || !m_last_data);
                e_cmd = dwins ? (DataWrite ? 3'b011 : 3'b010) : 3'b001;
                e_addr = dwins ? DataAddr : IfAddr;
                k = $urandom_range(1, TO);
                rd = $urandom;
                do_xfer(k, 1, rd, o);
                if (dwins && !DataWrite) m_dr = rd;
                if (!dwins) m_if = rd;
                checks++;
                if ({o.cmd, o.addr, o.held_ok} !== {e_cmd, e_addr, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL rand_grant%0d: got %h expected %h", it, {o.cmd, o.addr, o.held_ok},
                             {e_cmd, e_addr, 1'b1});
                end
                checks++;
                if ({o.acks, o.turn_acks} !== {!dwins, dwins, 1'b0, 3'b000}) begin
                    errors++;
                    $display("[TB] FAIL rand_ack%0d: got %b expected %b", it, {o.acks, o.turn_acks},
                             {!dwins, dwins, 1'b0, 3'b000});
                end
                checks++;
                if ({o.if_data, o.d_rdata} !== {m_if, m_dr}) begin
                    errors++;
                    $display("[TB] FAIL rand_data%0d: got %h expected %h", it, {o.if_data, o.d_rdata}, {m_if, m_dr});
                end
                if (dwins && DataWrite) begin
                    checks++;
                    if ({o.wen, o.wdata} !== {1'b1, DataWData}) begin
                        errors++;
                        $display("[TB] FAIL rand_wdata%0d: got %h expected %h", it, {o.wen, o.wdata}, {1'b1, DataWData});
                    end
                end
                m_last_data = dwins;
                if (dwins) DataReq = 0;
                else IfReq = 0;
            end
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs;
        @(negedge clk);
        test_reset;
        test_single_fetch;
        test_store;
        test_contention;
        test_timeout;
        test_boundary_ready;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_bus_arbiter.md
# ext_bus_arbiter

Sequencer and arbiter for the CPU's single external memory bus. It serves two requesters: the instruction-fetch path driven by the PC, and the load/store data path driven by the ALU address. It grants the bus to one requester at a time and drives the external command code, address and write data. It waits on the external ready handshake, returns read data with a one-cycle acknowledge, and aborts transfers that exceed a cycle budget. It sits between the core (PC/ALU/register file) and the external memory interface, replacing ad-hoc per-source bus driving.

## Interface
- TIMEOUT_CYCLES, 255: max cycles a transfer waits for BusReady before abort (1..255, counter is 8 bits).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- IfReq  in  1  instruction fetch request; held until IfAck.
- IfAddr  in  32  fetch address (PC); stable while IfReq.
- IfAck  out  1  one-cycle pulse: fetch done (or aborted).
- IfData  out  32  fetched instruction; valid from IfAck until next IfAck.
- DataReq  in  1  load/store request; held until DataAck.
- DataWrite  in  1  1 = store, 0 = load; stable while DataReq.
- DataAddr  in  32  load/store address.
- DataWData  in  32  store data.
- DataAck  out  1  one-cycle pulse: load/store done (or aborted).
- DataRData  out  32  load data; valid from DataAck until next DataAck.
- BusCmd  out  3  000 idle, 001 fetch, 010 mem read, 011 mem write; others never driven.
- BusAddr  out  32  external address.
- BusWData  out  32  external write data.
- BusWEn  out  1  1 = block drives external data bus (write only).
- BusRData  in  32  external read data.
- BusReady  in  1  external exchange complete.
- Timeout  out  1  one-cycle pulse, coincident with the aborting Ack.

## Operation
- States: IDLE, FETCH, DREAD, DWRITE, TURN.
- IDLE: BusCmd=000, BusWEn=0.
  - Only IfReq: go to FETCH; latch BusAddr=IfAddr.
  - Only DataReq: go to DREAD or DWRITE per DataWrite; latch BusAddr=DataAddr, and BusWData=DataWData for a write.
  - Both: grant the requester not served last (LastWasData flag). LastWasData resets to 0, so data wins the first tie. Strict alternation under continuous contention.
- FETCH/DREAD/DWRITE:
  - BusCmd is 001/010/011 respectively. BusWEn=1 only in DWRITE. BusAddr and BusWData are held constant.
  - 8-bit wait counter cleared on entry, incremented each cycle BusReady=0.
  - BusReady=1:
    - FETCH: capture BusRData into IfData, pulse IfAck.
    - DREAD: capture BusRData into DataRData, pulse DataAck.
    - DWRITE: pulse DataAck.
    - Update LastWasData; go to TURN.
  - Counter reaches TIMEOUT_CYCLES with BusReady=0:
    - Abort and go to TURN.
    - Pulse the owner's Ack together with Timeout.
    - Read data register loads 32'h0000_0000.
  - BusReady=1 on the terminal count cycle counts as success, not timeout.
- TURN: BusCmd=000, BusWEn=0. Always go to IDLE. This guarantees a requester's still-high Req in the Ack cycle is never re-serviced, and gives one bus turnaround cycle.
- BusReady in IDLE/TURN is ignored.
- Req inputs changing mid-transfer are ignored; payload was latched at grant.

## Timing
- Reset (rst=1 at edge): state IDLE, BusCmd=000, BusAddr=0, BusWData=0, BusWEn=0, IfAck=0, DataAck=0, Timeout=0, IfData=0, DataRData=0, LastWasData=0, counter=0.
  - Reset mid-transfer aborts without any Ack.
  - Bus goes idle in the cycle after the reset edge.
- Grant latency: Req high at edge N in IDLE gives BusCmd/BusAddr valid after edge N.
- BusReady sampled high at edge N+k (k≥1) gives Ack and data valid after edge N+k, for one cycle.
- Edge N+k+1 is in TURN; edge N+k+2 is IDLE and can grant again.
- Zero-wait throughput is one transfer per 3 cycles.
- Timeout: with BusReady held 0, Ack+Timeout appear after edge N+TIMEOUT_CYCLES.
- IfAck and DataAck are never high in the same cycle.

## Test plan
- Reset then single fetch:
  - Stimulus: IfAddr=0x100, BusReady high 2 cycles after BusCmd=001, BusRData=0xDEADBEEF.
  - Response: IfAck one pulse, IfData=0xDEADBEEF, BusCmd back to 000 in TURN.
- Store:
  - Stimulus: DataAddr=0x2000, DataWData=0x12345678, DataWrite=1.
  - Response: BusCmd=011, BusWEn=1, BusAddr/BusWData match and are held until BusReady, DataAck pulse, BusWEn=0 after.
- Contention:
  - Stimulus: IfReq and DataReq (load) both held continuously from reset, ready zero-wait.
  - Response: grant order DREAD, FETCH, DREAD, FETCH; each transfer 3 cycles apart; no double Ack.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, load to 0x40, BusReady never asserted.
  - Response: DataAck+Timeout after 4 cycles in DREAD, DataRData=0.
  - Next request is still served normally.
- Boundary ready:
  - Stimulus: BusReady asserted exactly on the terminal count cycle.
  - Response: success, Timeout=0, data captured.
- Reset mid-transfer:
  - Stimulus: rst=1 during FETCH wait.
  - Response: no IfAck, all outputs at reset values next cycle, fresh IfReq served normally after rst=0.
